// File: rtl/seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder
//
// Purpose:
//   Multi-cycle ripple adder. Computes {cout, s} = a + b + cin one CHUNK-bit
//   slice per clock, least significant slice first. A request is accepted in
//   IDLE (or in DONE, for back-to-back use). The operation then spends
//   N = WIDTH/CHUNK cycles in RUN and finishes with a single DONE cycle.
//
// Parameters:
//   WIDTH  operand and sum width in bits (default 16)
//   CHUNK  bits added per clock cycle (default 4). WIDTH must be a multiple
//          of CHUNK.
//
// Ports:
//   clk    input   rising-edge clock
//   rst_n  input   asynchronous active-low reset
//   start  input   request a new addition; sampled only in IDLE or DONE
//   a, b   input   WIDTH-bit operands, latched together with start
//   cin    input   carry-in, latched together with start
//   busy   output  high while the addition is in progress (RUN)
//   done   output  one-cycle pulse while s/cout hold a fresh result (DONE)
//   s      output  WIDTH-bit sum; changes only on entry to DONE or on reset
//   cout   output  carry-out of the full addition
//   ovf    output  two's-complement signed overflow (optional, see below)
//
// Configuration:
//   Define SEQ_CHUNK_ADDER_OVF_EN to add the ovf output and its register.
//   With the macro undefined, the port and its logic do not exist and the
//   rest of the behaviour is unchanged.
// ---------------------------------------------------------------------------
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / CHUNK;
  // A one-slice configuration still needs a 1-bit index so that the
  // declarations stay legal.
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;

  // Operands and carry-in are captured once at acceptance. The input pins
  // are not looked at again until the next acceptance.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Partial sums build up here while RUN is active. The visible s register
  // is only loaded from it on the final slice, so s stays stable during RUN.
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [31:0]      slice_base;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_carry;
  logic             last_slice;
  logic [WIDTH-1:0] merged_sum;

  // Slice datapath: select the operand bits for the current index, add them
  // with the registered carry, and drop the partial sum into its position
  // within the accumulator.
  always_comb begin
    slice_base  = 32'(idx_q) * 32'(CHUNK);
    a_slice     = a_q[slice_base +: CHUNK];
    b_slice     = b_q[slice_base +: CHUNK];
    {slice_carry, slice_sum} = {1'b0, a_slice} + {1'b0, b_slice}
                             + {{CHUNK{1'b0}}, carry_q};
    last_slice  = (idx_q == IDX_W'(N - 1));
    merged_sum  = acc_q;
    merged_sum[slice_base +: CHUNK] = slice_sum;
  end

  // Next-state and output decode. The index wraps to zero on the last slice
  // instead of counting past N-1. This keeps the slice select in range even
  // while the FSM sits in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        busy    = 1'b1;
        acc_d   = merged_sum;
        carry_d = slice_carry;
        if (last_slice) begin
          idx_d   = '0;
          s_d     = merged_sum;
          cout_d  = slice_carry;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
          // Carry into the MSB equals a^b^s at that bit. Overflow is that
          // carry XOR the carry out of the MSB.
          ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ merged_sum[WIDTH-1]
                  ^ slice_carry;
`endif
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        done = 1'b1;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything without waiting
  // for a clock edge, which also abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_chunk_adder
//
// Self-checking bench for seq_chunk_adder. Three instances are used:
//   u16  WIDTH=16, CHUNK=4  (N=4)
//   u8   WIDTH=8,  CHUNK=4  (N=2)
//   uw   WIDTH=16, CHUNK=16 (N=1)
// Inputs are driven and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst_n;

  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, s16;
  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, s8;
  logic        startw, cinw, busyw, donew, coutw;
  logic [15:0] aw, bw, sw;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic        ovf16, ovf8, ovfw;
`endif

  int checks;
  int failures;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .s(s16), .cout(cout16)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) uw (
    .clk(clk), .rst_n(rst_n), .start(startw), .a(aw), .b(bw), .cin(cinw),
    .busy(busyw), .done(donew), .s(sw), .cout(coutw)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    , .ovf(ovfw)
`endif
  );

  // Reset is asserted before the first rising edge. Outputs must already
  // be zero at that point.
  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || s16 !== 16'h0 || cout16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_u16 busy=%b done=%b s=%h cout=%b, want all zero",
               busy16, done16, s16, cout16);
    end
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || s8 !== 8'h0 || cout8 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_u8 busy=%b done=%b s=%h cout=%b, want all zero",
               busy8, done8, s8, cout8);
    end
    checks++;
    if (busyw !== 1'b0 || donew !== 1'b0 || sw !== 16'h0 || coutw !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_uw busy=%b done=%b s=%h cout=%b, want all zero",
               busyw, donew, sw, coutw);
    end
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    checks++;
    if (ovf16 !== 1'b0 || ovf8 !== 1'b0 || ovfw !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ovf ovf16=%b ovf8=%b ovfw=%b, want 0", ovf16, ovf8, ovfw);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Add FFFF + 0001. busy stays high for four cycles and done follows on
  // the fourth edge after start. Start is driven on the first edge after
  // reset is released.
  task automatic test_basic;
    start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy16 !== 1'b1 || done16 !== 1'b0 || s16 !== 16'h0000 || cout16 !== 1'b0) begin
        failures++;
        $display("[TB] FAIL basic_run cyc=%0d busy=%b done=%b s=%h cout=%b, want busy=1 done=0 s=0000 cout=0",
                 k, busy16, done16, s16, cout16);
      end
      @(negedge clk);
    end
    checks++;
    if (done16 !== 1'b1 || busy16 !== 1'b0 || s16 !== 16'h0000 || cout16 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_done done=%b busy=%b s=%h cout=%b, want done=1 busy=0 s=0000 cout=1",
               done16, busy16, s16, cout16);
    end
    @(negedge clk);
    checks++;
    if (done16 !== 1'b0 || busy16 !== 1'b0 || s16 !== 16'h0000 || cout16 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_idle done=%b busy=%b s=%h cout=%b, want done=0 busy=0 s=0000 cout=1",
               done16, busy16, s16, cout16);
    end
  endtask

  // Directed 16-bit vectors with hand-computed sums. Each new operation is
  // issued in the DONE cycle of the previous one. The old result must hold
  // throughout RUN.
  task automatic test_vectors16;
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic        vc [6];
    logic [15:0] es [6];
    logic        ec [6];
    logic        eo [6];
    logic [15:0] prev_s;
    logic        prev_c;
    va = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0FFF, 16'h7FFF, 16'hABCD};
    vb = '{16'h1111, 16'hFFFF, 16'h8000, 16'h0001, 16'h0001, 16'h5432};
    vc = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b0,     1'b1};
    es = '{16'h2345, 16'hFFFF, 16'h0000, 16'h1000, 16'h8000, 16'h0000};
    ec = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b1};
    eo = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
    prev_s = 16'h0000;
    prev_c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start16 = 1'b1; a16 = va[i]; b16 = vb[i]; cin16 = vc[i];
      @(negedge clk);
      start16 = 1'b0;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (busy16 !== 1'b1 || done16 !== 1'b0 || s16 !== prev_s || cout16 !== prev_c) begin
          failures++;
          $display("[TB] FAIL vec16_hold i=%0d cyc=%0d busy=%b done=%b s=%h cout=%b, want busy=1 done=0 s=%h cout=%b",
                   i, k, busy16, done16, s16, cout16, prev_s, prev_c);
        end
        @(negedge clk);
      end
      checks++;
      if (done16 !== 1'b1 || s16 !== es[i] || cout16 !== ec[i]) begin
        failures++;
        $display("[TB] FAIL vec16_sum i=%0d done=%b s=%h cout=%b, want done=1 s=%h cout=%b",
                 i, done16, s16, cout16, es[i], ec[i]);
      end
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      checks++;
      if (ovf16 !== eo[i]) begin
        failures++;
        $display("[TB] FAIL vec16_ovf i=%0d ovf=%b, want %b", i, ovf16, eo[i]);
      end
`else
      if (eo[i] === 1'bx) $display("[TB] note: unexpected x in ovf table");
`endif
      prev_s = es[i];
      prev_c = ec[i];
    end
    @(negedge clk);
  endtask

  // 8-bit adder across corner operand values and both carry-ins. done must
  // appear exactly two edges after start and not one edge after it.
  task automatic test_exhaustive8;
    logic [7:0] vals [8];
    logic [8:0] exp9;
    vals = '{8'h00, 8'h01, 8'h0F, 8'h7F, 8'h80, 8'hAA, 8'hFE, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        for (int c = 0; c < 2; c++) begin
          start8 = 1'b1; a8 = vals[i]; b8 = vals[j]; cin8 = 1'(c);
          exp9 = {1'b0, vals[i]} + {1'b0, vals[j]} + 9'(c);
          @(negedge clk);
          start8 = 1'b0;
          @(negedge clk);
          checks++;
          if (done8 !== 1'b0 || busy8 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lat8_early a=%h b=%h cin=%0d done=%b busy=%b, want done=0 busy=1",
                     vals[i], vals[j], c, done8, busy8);
          end
          @(negedge clk);
          checks++;
          if (done8 !== 1'b1 || {cout8, s8} !== exp9) begin
            failures++;
            $display("[TB] FAIL sum8 a=%h b=%h cin=%0d done=%b result=%h, want done=1 result=%h",
                     vals[i], vals[j], c, done8, {cout8, s8}, exp9);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  // start stays high with a new operand on each of the three cycles after
  // acceptance. Those requests land in RUN and must be dropped.
  task automatic test_start_during_run;
    start16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0;
    @(negedge clk);
    a16 = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy16 !== 1'b1 || done16 !== 1'b0) begin
        failures++;
        $display("[TB] FAIL run_ignore_busy cyc=%0d busy=%b done=%b, want busy=1 done=0",
                 k, busy16, done16);
      end
      @(negedge clk);
    end
    start16 = 1'b0;
    @(negedge clk);
    checks++;
    if (done16 !== 1'b1 || s16 !== 16'h2345 || cout16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL run_ignore_sum done=%b s=%h cout=%b, want done=1 s=2345 cout=0",
               done16, s16, cout16);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (done16 !== 1'b0 || busy16 !== 1'b0 || s16 !== 16'h2345) begin
        failures++;
        $display("[TB] FAIL run_ignore_extra cyc=%0d done=%b busy=%b s=%h, want done=0 busy=0 s=2345",
                 k, done16, busy16, s16);
      end
    end
  endtask

  // Reset pulled in the second RUN cycle clears outputs at once. No done
  // may follow. A fresh operation afterwards completes normally.
  task automatic test_reset_mid_run;
    start16 = 1'b1; a16 = 16'h0F0F; b16 = 16'h0101; cin16 = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (s16 !== 16'h0000 || cout16 !== 1'b0 || busy16 !== 1'b0 || done16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_clear s=%h cout=%b busy=%b done=%b, want all zero",
               s16, cout16, busy16, done16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (done16 !== 1'b0 || busy16 !== 1'b0 || s16 !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL midrst_nodone cyc=%0d done=%b busy=%b s=%h, want done=0 busy=0 s=0000",
                 k, done16, busy16, s16);
      end
      @(negedge clk);
    end
    start16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy16 !== 1'b1 || done16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_fresh_run busy=%b done=%b, want busy=1 done=0", busy16, done16);
    end
    @(negedge clk);
    checks++;
    if (done16 !== 1'b1 || s16 !== 16'h3334 || cout16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_fresh_sum done=%b s=%h cout=%b, want done=1 s=3334 cout=0",
               done16, s16, cout16);
    end
    @(negedge clk);
  endtask

  // CHUNK=WIDTH with start held high. Operations alternate RUN and DONE, so
  // done pulses every second cycle. s holds across each RUN cycle.
  task automatic test_back_to_back;
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic        vc [4];
    logic [15:0] es [4];
    logic        ec [4];
    logic [15:0] prev_s;
    va = '{16'h0001, 16'hFFFF, 16'h8000, 16'h1234};
    vb = '{16'h0002, 16'h0001, 16'h8000, 16'h4321};
    vc = '{1'b0,     1'b0,     1'b1,     1'b1};
    es = '{16'h0003, 16'h0000, 16'h0001, 16'h5556};
    ec = '{1'b0,     1'b1,     1'b1,     1'b0};
    prev_s = 16'h0000;
    startw = 1'b1; aw = va[0]; bw = vb[0]; cinw = vc[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (busyw !== 1'b1 || donew !== 1'b0 || sw !== prev_s) begin
        failures++;
        $display("[TB] FAIL b2b_run i=%0d busy=%b done=%b s=%h, want busy=1 done=0 s=%h",
                 i, busyw, donew, sw, prev_s);
      end
      if (i < 3) begin
        aw = va[i+1]; bw = vb[i+1]; cinw = vc[i+1];
      end
      @(negedge clk);
      checks++;
      if (donew !== 1'b1 || busyw !== 1'b0 || sw !== es[i] || coutw !== ec[i]) begin
        failures++;
        $display("[TB] FAIL b2b_done i=%0d done=%b busy=%b s=%h cout=%b, want done=1 busy=0 s=%h cout=%b",
                 i, donew, busyw, sw, coutw, es[i], ec[i]);
      end
      prev_s = es[i];
    end
    startw = 1'b0;
    @(negedge clk);
    checks++;
    if (donew !== 1'b0 || busyw !== 1'b0 || sw !== prev_s) begin
      failures++;
      $display("[TB] FAIL b2b_idle done=%b busy=%b s=%h, want done=0 busy=0 s=%h",
               donew, busyw, sw, prev_s);
    end
  endtask

  // Sequence of scenarios followed by the summary line.
  initial begin
    checks   = 0;
    failures = 0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0;
    startw  = 1'b0; aw  = '0; bw  = '0; cinw  = 1'b0;
    test_reset;
    test_basic;
    test_vectors16;
    test_exhaustive8;
    test_start_during_run;
    test_reset_mid_run;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Runaway guard. Every scenario is bounded, so this fires only if the
  // sequence stalls.
  initial begin
    #500000;
    $display("[TB] FAIL timeout simulation exceeded time limit, checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, with 1 <= CHUNK <= WIDTH.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, request to begin an addition.
REQ-006 SHALL have port a, input, WIDTH, first operand.
REQ-007 SHALL have port b, input, WIDTH, second operand.
REQ-008 SHALL have port cin, input, 1, carry-in.
REQ-009 SHALL have port busy, output, 1, high while an addition is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse marking that the result is valid.
REQ-011 SHALL have port s, output, WIDTH, sum.
REQ-012 SHALL have port cout, output, 1, carry-out.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE, where N = WIDTH/CHUNK.
REQ-014 In IDLE, start=1 SHALL latch a, b and cin into internal registers, clear the slice index, and enter RUN; a, b and cin SHALL be ignored at all other times.
REQ-015 Each RUN cycle SHALL add operand slice i (bits i*CHUNK+CHUNK-1 : i*CHUNK) plus the registered carry, store the CHUNK-bit partial sum and the new carry, and increment i.
REQ-016 Slice 0 SHALL use the latched cin as its carry-in.
REQ-017 After the N-th RUN cycle, the FSM SHALL enter DONE.
REQ-018 On the edge entering DONE, s and cout SHALL update to the full result.
REQ-019 The done pulse SHALL assert exactly N cycles after the edge that sampled start.
REQ-020 The result SHALL equal {cout,s} = a + b + cin, computed at WIDTH+1 bits with no truncation of the carry.
REQ-021 s and cout SHALL change only on entry to DONE or on reset, and SHALL hold otherwise, including throughout RUN.
REQ-022 busy SHALL be 1 exactly while the FSM is in RUN.
REQ-023 done SHALL be 1 exactly while the FSM is in DONE, which lasts one cycle.
REQ-024 start while in RUN SHALL be ignored; the operation in flight SHALL be unaffected and no request SHALL be queued.
REQ-025 start=1 while in DONE SHALL be accepted as if in IDLE, giving back-to-back operations with one done cycle between them.
REQ-026 Otherwise, DONE SHALL return to IDLE.
REQ-027 With CHUNK=WIDTH, N=1: the FSM SHALL spend one cycle in RUN and done SHALL assert 1 cycle after start.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force the FSM to IDLE and set busy=0, done=0, s=0, cout=0, and clear all internal operand, carry and index registers.
REQ-029 Reset asserted during RUN or DONE SHALL abandon the operation; no done pulse SHALL follow for that operation.
REQ-030 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-031 With macro SEQ_CHUNK_ADDER_OVF_EN defined, the block SHALL add output ovf (1 bit) giving the two's-complement signed overflow of a+b+cin.
REQ-032 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, updating and resetting with s.
REQ-033 Without the macro, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 WIDTH=16, CHUNK=4, a=16'hFFFF, b=16'h0001, cin=0, start pulse -> busy high 4 cycles, done high on cycle 4 after start, s=16'h0000, cout=1.
REQ-035 WIDTH=8, CHUNK=4, all 2^17 combinations of a, b and cin -> every {cout,s} equals a+b+cin (9-bit), each with done latency 2.
REQ-036 Start a=16'h1234, b=16'h1111, then drive start with a=16'hFFFF on each of the next 3 cycles (during RUN) -> single done with s=16'h2345, cout=0; no second done.
REQ-037 Pull rst_n low at cycle 2 of RUN (16/4) -> s=0, cout=0, busy=0 immediately, no done; a fresh start then completes correctly.
REQ-038 start held high continuously, WIDTH=16, CHUNK=16 -> done every 2nd cycle; s tracks each new a+b+cin; s stable between done pulses.
REQ-039 With SEQ_CHUNK_ADDER_OVF_EN defined, a=16'h7FFF, b=16'h0001, cin=0 -> s=16'h8000, ovf=1, cout=0; a=16'h8000, b=16'h8000 -> s=0, ovf=1, cout=1.
